// File: rtl/fa_pkg.sv
// Shared types and constants for the ripple-carry full adder (fa) and its 1-bit cell.
// The optional overflow outputs are controlled by FA_OVF_EN in the top level.
package fa_pkg;

    localparam int FA_MAX_WIDTH = 64;

    typedef struct packed {
        logic s;
        logic co;
    } fa_bit_t;

    // Single-cell full-adder equations, shared so the cell and any future users agree.
    function automatic fa_bit_t fa_cell(input logic a, input logic b, input logic ci);
        fa_bit_t r;
        r.s  = a ^ b ^ ci;
        r.co = (a & b) | (ci & (a ^ b));
        return r;
    endfunction

endpackage

// File: rtl/fa_bit.sv
// One-bit full-adder cell, the link of the ripple-carry chain in fa.
// Purely combinational; carry-out feeds the next cell's carry-in.
module fa_bit
    import fa_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    fa_bit_t res;

    assign res = fa_cell(a, b, ci);
    assign s   = res.s;
    assign co  = res.co;

endmodule

// File: rtl/fa.sv
// WIDTH-bit ripple-carry full adder with combinational sum/carry and a registered copy.
// Define FA_OVF_EN to add the signed-overflow outputs ovf and ovf_q.
module fa
    import fa_pkg::*;
#(
    parameter int WIDTH = 1   // legal range 1..FA_MAX_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic [WIDTH-1:0] sum_q,
`ifdef FA_OVF_EN
    output logic             carry_q,
    output logic             ovf,
    output logic             ovf_q
`else
    output logic             carry_q
`endif
);

    // c[i] is the carry into bit i; c[WIDTH] is the carry-out of the MSB.
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] sum_d;
    logic             carry_d;

    assign c[0] = c_in;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        fa_bit u_bit (
            .a  (a_in[i]),
            .b  (b_in[i]),
            .ci (c[i]),
            .s  (sum[i]),
            .co (c[i+1])
        );
    end

    assign carry = c[WIDTH];

`ifdef FA_OVF_EN
    logic ovf_d;

    // Carries into and out of the sign bit disagree exactly on signed overflow.
    assign ovf = c[WIDTH] ^ c[WIDTH-1];
`endif

    // NOTE: every always_comb output gets its value on every path (default first),
    // so no latch can be inferred; the synchronous clear is folded into the _d term.
    always_comb begin
        sum_d   = sum;
        carry_d = carry;
`ifdef FA_OVF_EN
        ovf_d   = ovf;
`endif
        if (rst) begin
            sum_d   = '0;
            carry_d = 1'b0;
`ifdef FA_OVF_EN
            ovf_d   = 1'b0;
`endif
        end
    end

    // NOTE: non-blocking assignments for flops, so all registers update together at the edge.
    always_ff @(posedge clk) begin
        sum_q   <= sum_d;
        carry_q <= carry_d;
`ifdef FA_OVF_EN
        ovf_q   <= ovf_d;
`endif
    end

endmodule

// File: tb/tb_fa.sv
// Self-checking bench for fa at WIDTH 1, 4 and 8: directed boundary cases plus random stimulus
// checked against an arithmetic reference model; overflow checks are active with FA_OVF_EN.
module tb_fa;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [0:0] a1, b1, s1, sq1;
    logic       c1, co1, coq1;
    logic [3:0] a4, b4, s4, sq4;
    logic       c4, co4, coq4;
    logic [7:0] a8, b8, s8, sq8;
    logic       c8, co8, coq8;
`ifdef FA_OVF_EN
    logic       o1, oq1, o4, oq4, o8, oq8;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fa #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst(rst), .a_in(a1), .b_in(b1), .c_in(c1),
        .sum(s1), .carry(co1), .sum_q(sq1), .carry_q(coq1)
`ifdef FA_OVF_EN
        , .ovf(o1), .ovf_q(oq1)
`endif
    );

    fa #(.WIDTH(4)) u_w4 (
        .clk(clk), .rst(rst), .a_in(a4), .b_in(b4), .c_in(c4),
        .sum(s4), .carry(co4), .sum_q(sq4), .carry_q(coq4)
`ifdef FA_OVF_EN
        , .ovf(o4), .ovf_q(oq4)
`endif
    );

    fa #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .a_in(a8), .b_in(b8), .c_in(c8),
        .sum(s8), .carry(co8), .sum_q(sq8), .carry_q(coq8)
`ifdef FA_OVF_EN
        , .ovf(o8), .ovf_q(oq8)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the operand values.
    function automatic int exp_sum(int w, int a, int b, int c);
        return (a + b + c) % (1 << w);
    endfunction

    function automatic int exp_carry(int w, int a, int b, int c);
        return (a + b + c) / (1 << w);
    endfunction

    // Signed view: operands as two's complement, carry-in as +1; overflow if out of range.
    function automatic int exp_ovf(int w, int a, int b, int c);
        int half = 1 << (w - 1);
        int sa   = (a >= half) ? a - (1 << w) : a;
        int sb   = (b >= half) ? b - (1 << w) : b;
        int t    = sa + sb + c;
        return ((t > half - 1) || (t < -half)) ? 1 : 0;
    endfunction

    task automatic check_comb(input string tag);
        check({tag, "_w1_sum"},   64'(s1),  64'(exp_sum  (1, int'(a1), int'(b1), int'(c1))));
        check({tag, "_w1_carry"}, 64'(co1), 64'(exp_carry(1, int'(a1), int'(b1), int'(c1))));
        check({tag, "_w4_sum"},   64'(s4),  64'(exp_sum  (4, int'(a4), int'(b4), int'(c4))));
        check({tag, "_w4_carry"}, 64'(co4), 64'(exp_carry(4, int'(a4), int'(b4), int'(c4))));
        check({tag, "_w8_sum"},   64'(s8),  64'(exp_sum  (8, int'(a8), int'(b8), int'(c8))));
        check({tag, "_w8_carry"}, 64'(co8), 64'(exp_carry(8, int'(a8), int'(b8), int'(c8))));
`ifdef FA_OVF_EN
        check({tag, "_w1_ovf"}, 64'(o1), 64'(exp_ovf(1, int'(a1), int'(b1), int'(c1))));
        check({tag, "_w4_ovf"}, 64'(o4), 64'(exp_ovf(4, int'(a4), int'(b4), int'(c4))));
        check({tag, "_w8_ovf"}, 64'(o8), 64'(exp_ovf(8, int'(a8), int'(b8), int'(c8))));
`endif
    endtask

    // Called #1 after a rising edge; inputs and rst have been stable since the previous falling edge.
    task automatic check_reg(input string tag);
        int k = rst ? 0 : 1;
        check({tag, "_w1_sum_q"},   64'(sq1),  64'(k * exp_sum  (1, int'(a1), int'(b1), int'(c1))));
        check({tag, "_w1_carry_q"}, 64'(coq1), 64'(k * exp_carry(1, int'(a1), int'(b1), int'(c1))));
        check({tag, "_w4_sum_q"},   64'(sq4),  64'(k * exp_sum  (4, int'(a4), int'(b4), int'(c4))));
        check({tag, "_w4_carry_q"}, 64'(coq4), 64'(k * exp_carry(4, int'(a4), int'(b4), int'(c4))));
        check({tag, "_w8_sum_q"},   64'(sq8),  64'(k * exp_sum  (8, int'(a8), int'(b8), int'(c8))));
        check({tag, "_w8_carry_q"}, 64'(coq8), 64'(k * exp_carry(8, int'(a8), int'(b8), int'(c8))));
`ifdef FA_OVF_EN
        check({tag, "_w1_ovf_q"}, 64'(oq1), 64'(k * exp_ovf(1, int'(a1), int'(b1), int'(c1))));
        check({tag, "_w4_ovf_q"}, 64'(oq4), 64'(k * exp_ovf(4, int'(a4), int'(b4), int'(c4))));
        check({tag, "_w8_ovf_q"}, 64'(oq8), 64'(k * exp_ovf(8, int'(a8), int'(b8), int'(c8))));
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] combo;
        logic [1:0] pairs [8];
        pairs = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};

        a1 = '0; b1 = '0; c1 = 1'b0;
        a4 = '0; b4 = '0; c4 = 1'b0;
        a8 = '0; b8 = '0; c8 = 1'b0;

        // 1-bit exhaustive sweep, combinational only; pairs are {sum, carry} in sweep order.
        for (int i = 0; i < 8; i++) begin
            combo = 3'(i);
            {a1, b1, c1} = combo;
            #10;
            check($sformatf("sweep%0d_sum", i),   64'(s1),  64'(pairs[i][1]));
            check($sformatf("sweep%0d_carry", i), 64'(co1), 64'(pairs[i][0]));
        end

        // Reset held for two edges: registers stay 0 while sum already follows the inputs.
        @(negedge clk);
        a1 = 1'b1; b1 = 1'b0; c1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_sum_q",   64'(sq1),  64'h0);
        check("rst_carry_q", 64'(coq1), 64'h0);
        check("rst_sum",     64'(s1),   64'h1);

        @(negedge clk);
        rst = 1'b0;
        a1 = 1'b1; b1 = 1'b1; c1 = 1'b0;
        @(posedge clk);
        #1;
        check("rel_carry_q", 64'(coq1), 64'h1);
        check("rel_sum_q",   64'(sq1),  64'h0);

        // 8-bit carry boundaries.
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'h01; c8 = 1'b0;
        #1;
        check("ff01_sum",   64'(s8),  64'h00);
        check("ff01_carry", 64'(co8), 64'h1);
        c8 = 1'b1;
        #1;
        check("ff01c_sum",   64'(s8),  64'h01);
        check("ff01c_carry", 64'(co8), 64'h1);
        a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
        #1;
        check("ffffc_sum",   64'(s8),  64'hFF);
        check("ffffc_carry", 64'(co8), 64'h1);
        a8 = 8'h00; b8 = 8'h00; c8 = 1'b0;
        #1;
        check("zero_sum",   64'(s8),  64'h00);
        check("zero_carry", 64'(co8), 64'h0);

`ifdef FA_OVF_EN
        a8 = 8'h7F; b8 = 8'h01; c8 = 1'b0;
        #1;
        check("ovf_7f01", 64'(o8), 64'h1);
        a8 = 8'h80; b8 = 8'hFF; c8 = 1'b0;
        #1;
        check("ovf_80ff",       64'(o8),  64'h1);
        check("ovf_80ff_carry", 64'(co8), 64'h1);
        a8 = 8'h01; b8 = 8'h01; c8 = 1'b0;
        #1;
        check("ovf_0101", 64'(o8), 64'h0);
`endif

        // 4-bit mid-stream reset: 0x9 + 0x8 + 1 = 0x12.
        @(negedge clk);
        a4 = 4'h9; b4 = 4'h8; c4 = 1'b1;
        @(posedge clk);
        #1;
        check("mid_pre_sum_q", 64'(sq4), 64'h2);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_sum_q",   64'(sq4),  64'h0);
        check("mid_rst_carry_q", 64'(coq4), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rel_sum_q",   64'(sq4),  64'h2);
        check("mid_rel_carry_q", 64'(coq4), 64'h1);

        // Random traffic with occasional reset pulses.
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            a1 = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom);
            a4 = 4'($urandom); b4 = 4'($urandom); c4 = 1'($urandom);
            a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
            rst = ($urandom_range(0, 7) == 0);
            #1;
            check_comb($sformatf("rnd%0d", n));
            @(posedge clk);
            #1;
            check_reg($sformatf("rnd%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
